// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Command-side sequencer for the 4-bit combinational ALU. Commands (A, B,
// opcode) are queued in a small FIFO. Each one is presented to the ALU in turn.
// The ALU inputs are held for SETTLE edges, then the result is captured and
// returned on a valid/ready response port. Only one operation is at the ALU at
// any time.
//
// Parameters
//   DEPTH   command FIFO entries (power of two, 2..16)
//   SETTLE  edges the ALU inputs are held before sampling alu_result (1..7)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_ready = (count < DEPTH)
//   cmd_a, cmd_b, cmd_op          command payload
//   alu_a, alu_b, alu_op          registered operands/opcode to the ALU
//   alu_result                    combinational ALU output
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_op            captured result and the opcode that made it
//   count                         FIFO occupancy
//   busy                          FSM not idle, or FIFO not empty
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [2:0]             cmd_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_op,
    input  logic [3:0]             alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_result,
    output logic [2:0]             rsp_op,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [2:0]    SETTLE_LOAD = 3'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // FIFO storage: {op, a, b}
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    state_t        state_q;
    logic [2:0]    settle_q;
    logic [3:0]    alu_a_q;
    logic [3:0]    alu_b_q;
    logic [2:0]    alu_op_q;
    logic          rsp_valid_q;
    logic [3:0]    rsp_result_q;
    logic [2:0]    rsp_op_q;

    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic          rsp_fire;
    logic [3:0]    head_a;
    logic [3:0]    head_b;
    logic [2:0]    head_op;

    // cmd_ready is derived from the registered count only, so a pop in the
    // same edge never lets a full FIFO accept a new command.
    assign cmd_ready     = (count_q < FULL_COUNT);
    assign push          = cmd_valid && cmd_ready;
    assign fifo_nonempty = (count_q != '0);
    assign rsp_fire      = rsp_valid_q && rsp_ready;

    // A pop happens on every entry into DRIVE: from IDLE, or straight from
    // WAIT when the held response is accepted and more work is queued.
    // count_q is registered, so a command pushed into an empty FIFO is not
    // visible here until the following edge (no bypass).
    assign pop = fifo_nonempty &&
                 ((state_q == S_IDLE) || ((state_q == S_WAIT) && rsp_fire));

    assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        settle_q <= SETTLE_LOAD;
                        state_q  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - 1'b1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_op_q     <= alu_op_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        if (pop) begin
                            settle_q <= SETTLE_LOAD;
                            state_q  <= S_DRIVE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // ALU inputs change only when a command is popped.
            if (pop) begin
                alu_a_q  <= head_a;
                alu_b_q  <= head_b;
                alu_op_q <= head_op;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign count      = count_q;
    assign busy       = (state_q != S_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Two instances (SETTLE=1 and SETTLE=3, DEPTH=4) share one stimulus stream.
// The ALU attached to each is alu_result = alu_a ^ alu_b. Each instance has a
// cycle-level behavioural model (queue + in-flight countdown + held response)
// checked every cycle, and a transaction scoreboard checking response order.
// Directed literal checks pin reset, single-op latency, backpressure,
// streaming spacing, the full boundary, wrap-around and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int NI    = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_a     = '0;
    logic [3:0] cmd_b     = '0;
    logic [2:0] cmd_op    = '0;
    logic       rsp_ready = 1'b0;

    logic                   cmd_ready_w  [NI];
    logic [3:0]             alu_a_w      [NI];
    logic [3:0]             alu_b_w      [NI];
    logic [2:0]             alu_op_w     [NI];
    logic [3:0]             alu_result_w [NI];
    logic                   rsp_valid_w  [NI];
    logic [3:0]             rsp_result_w [NI];
    logic [2:0]             rsp_op_w     [NI];
    logic [$clog2(DEPTH):0] count_w      [NI];
    logic                   busy_w       [NI];

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int acc_cnt [NI];
    int rsp_cnt [NI];

    // handshake log of the SETTLE=3 instance
    int         hs_cyc [$];
    logic [3:0] hs_res [$];
    logic [2:0] hs_op  [$];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int S = (gi == 0) ? 1 : 3;

        alu_cmd_issuer #(.DEPTH(DEPTH), .SETTLE(S)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid  (cmd_valid),
            .cmd_ready  (cmd_ready_w[gi]),
            .cmd_a      (cmd_a),
            .cmd_b      (cmd_b),
            .cmd_op     (cmd_op),
            .alu_a      (alu_a_w[gi]),
            .alu_b      (alu_b_w[gi]),
            .alu_op     (alu_op_w[gi]),
            .alu_result (alu_result_w[gi]),
            .rsp_valid  (rsp_valid_w[gi]),
            .rsp_ready  (rsp_ready),
            .rsp_result (rsp_result_w[gi]),
            .rsp_op     (rsp_op_w[gi]),
            .count      (count_w[gi]),
            .busy       (busy_w[gi])
        );

        assign alu_result_w[gi] = alu_a_w[gi] ^ alu_b_w[gi];

        // Behavioural model: a queue of waiting commands, at most one command
        // at the ALU with a count of edges until its result is sampled, and a
        // held response awaiting acceptance.
        cmd_t       m_q [$];
        bit         m_run;
        int         m_left;
        cmd_t       m_cur;
        cmd_t       m_drv;
        bit         m_hold;
        logic [3:0] m_res;
        logic [2:0] m_rop;
        cmd_t       sb_q [$];

        initial forever begin : model
            bit   take_cmd;
            bit   take_rsp;
            bit   start;
            cmd_t c;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_run  = 1'b0;
                m_left = 0;
                m_cur  = '0;
                m_drv  = '0;
                m_hold = 1'b0;
                m_res  = '0;
                m_rop  = '0;
            end else begin
                take_cmd = cmd_valid && (m_q.size() < DEPTH);
                take_rsp = m_hold && rsp_ready;
                start    = (m_q.size() != 0) && !m_run && (!m_hold || take_rsp);
                if (m_run) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_run  = 1'b0;
                        m_hold = 1'b1;
                        m_res  = m_cur.a ^ m_cur.b;
                        m_rop  = m_cur.op;
                    end
                end
                if (take_rsp) m_hold = 1'b0;
                if (start) begin
                    m_cur  = m_q.pop_front();
                    m_drv  = m_cur;
                    m_run  = 1'b1;
                    m_left = S;
                end
                if (take_cmd) begin
                    c.a = cmd_a;
                    c.b = cmd_b;
                    c.op = cmd_op;
                    m_q.push_back(c);
                end
            end
        end

        initial forever begin : compare
            @(negedge clk);
            if (chk_en) begin
                chk($sformatf("i%0d_cmd_ready", gi), int'(cmd_ready_w[gi]), (m_q.size() < DEPTH) ? 1 : 0);
                chk($sformatf("i%0d_count", gi), int'(count_w[gi]), m_q.size());
                chk($sformatf("i%0d_busy", gi), int'(busy_w[gi]),
                    (m_run || m_hold || m_q.size() != 0) ? 1 : 0);
                chk($sformatf("i%0d_rsp_valid", gi), int'(rsp_valid_w[gi]), int'(m_hold));
                chk($sformatf("i%0d_rsp_result", gi), int'(rsp_result_w[gi]), int'(m_res));
                chk($sformatf("i%0d_rsp_op", gi), int'(rsp_op_w[gi]), int'(m_rop));
                chk($sformatf("i%0d_alu_a", gi), int'(alu_a_w[gi]), int'(m_drv.a));
                chk($sformatf("i%0d_alu_b", gi), int'(alu_b_w[gi]), int'(m_drv.b));
                chk($sformatf("i%0d_alu_op", gi), int'(alu_op_w[gi]), int'(m_drv.op));
            end
        end

        // Transaction scoreboard: handshakes predicted from pre-edge values.
        initial forever begin : scoreboard
            cmd_t e;
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
            end else begin
                if (rsp_valid_w[gi] && rsp_ready) begin
                    chk($sformatf("i%0d_sb_expected_pending", gi), (sb_q.size() > 0) ? 1 : 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk($sformatf("i%0d_sb_result", gi), int'(rsp_result_w[gi]), int'(e.a ^ e.b));
                        chk($sformatf("i%0d_sb_op", gi), int'(rsp_op_w[gi]), int'(e.op));
                    end
                    rsp_cnt[gi]++;
                    $display("[TB] i%0d rsp #%0d result=%h op=%0d", gi, rsp_cnt[gi],
                             rsp_result_w[gi], rsp_op_w[gi]);
                end
                if (cmd_valid && cmd_ready_w[gi]) begin
                    e.a = cmd_a;
                    e.b = cmd_b;
                    e.op = cmd_op;
                    sb_q.push_back(e);
                    acc_cnt[gi]++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid_w[1] && rsp_ready) begin
            hs_cyc.push_back(cyc);
            hs_res.push_back(rsp_result_w[1]);
            hs_op.push_back(rsp_op_w[1]);
        end
    end

    task automatic drain();
        int g = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((busy_w[0] || busy_w[1]) && g < 300) begin
            step();
            g++;
        end
        chk("drain_timeout", (g >= 300) ? 1 : 0, 0);
    endtask

    initial begin
        int g;
        int base0;
        int base1;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_cmd_ready", int'(cmd_ready_w[k]), 1);
            chk("rst_count", int'(count_w[k]), 0);
            chk("rst_busy", int'(busy_w[k]), 0);
            chk("rst_rsp_valid", int'(rsp_valid_w[k]), 0);
            chk("rst_alu_a", int'(alu_a_w[k]), 0);
        end

        // ---------------- single op ----------------
        cmd_a = 4'b1100; cmd_b = 4'b0001; cmd_op = 3'b000; cmd_valid = 1'b1;
        step();                                   // edge 0: push
        cmd_valid = 1'b0;
        step();                                   // edge 1: pop
        chk("single_alu_a", int'(alu_a_w[0]), 4'hC);
        chk("single_alu_b", int'(alu_b_w[0]), 4'h1);
        step();                                   // edge 2
        chk("single_rsp_valid_s1", int'(rsp_valid_w[0]), 1);
        chk("single_rsp_result_s1", int'(rsp_result_w[0]), 4'hD);
        chk("single_rsp_op_s1", int'(rsp_op_w[0]), 0);
        chk("single_rsp_valid_s3_early", int'(rsp_valid_w[1]), 0);
        step();
        step();                                   // edge 4
        chk("single_rsp_valid_s3", int'(rsp_valid_w[1]), 1);
        chk("single_rsp_result_s3", int'(rsp_result_w[1]), 4'hD);

        // ---------------- backpressure ----------------
        for (int k = 0; k < 5; k++) begin
            cmd_a = 4'(k + 2); cmd_b = 4'(3 * k); cmd_op = 3'(k); cmd_valid = 1'b1;
            if (k == 4) begin
                chk("bp_fifth_ready", int'(cmd_ready_w[0]), 0);
                chk("bp_fifth_count", int'(count_w[0]), 4);
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_count_s1", int'(count_w[0]), 4);
        chk("bp_count_s3", int'(count_w[1]), 4);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_hold_valid", int'(rsp_valid_w[0]), 1);
            chk("bp_hold_result", int'(rsp_result_w[0]), 4'hD);
        end
        drain();

        // ---------------- streaming (SETTLE=3 instance) ----------------
        hs_cyc.delete(); hs_res.delete(); hs_op.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_a = 4'(i); cmd_b = 4'hF; cmd_op = 3'(i); cmd_valid = 1'b1;
            g = 0;
            while (!cmd_ready_w[1] && g < 50) begin
                step();
                g++;
            end
            step();
        end
        cmd_valid = 1'b0;
        g = 0;
        while (hs_res.size() < 8 && g < 200) begin
            step();
            g++;
        end
        chk("stream_rsp_count", hs_res.size(), 8);
        for (int i = 0; i < 8 && i < hs_res.size(); i++) begin
            chk($sformatf("stream_result_%0d", i), int'(hs_res[i]), i ^ 15);
            chk($sformatf("stream_op_%0d", i), int'(hs_op[i]), i % 8);
            if (i > 0) chk($sformatf("stream_spacing_%0d", i), hs_cyc[i] - hs_cyc[i-1], 4);
        end
        drain();

        // ---------------- full boundary ----------------
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        g = 0;
        while (!(count_w[0] == 3'd4 && count_w[1] == 3'd4 && rsp_valid_w[0] && rsp_valid_w[1])
               && g < 50) begin
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
            step();
            g++;
        end
        chk("full_fill_timeout", (g >= 50) ? 1 : 0, 0);
        chk("full_ready_low", int'(cmd_ready_w[0]), 0);
        rsp_ready = 1'b1;                         // pop this edge, cmd_valid still high
        step();
        chk("full_count_after_pop_s1", int'(count_w[0]), 3);
        chk("full_count_after_pop_s3", int'(count_w[1]), 3);
        chk("full_ready_rises", int'(cmd_ready_w[0]), 1);
        cmd_valid = 1'b0;
        drain();

        // ---------------- wrap-around ----------------
        base0 = acc_cnt[0];
        base1 = acc_cnt[1];
        g = 0;
        while ((acc_cnt[0] - base0 < 3 * DEPTH + 1 || acc_cnt[1] - base1 < 3 * DEPTH + 1) && g < 2000) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            g++;
        end
        cmd_valid = 1'b0;
        chk("wrap_push_timeout", (g >= 2000) ? 1 : 0, 0);
        g = 0;
        while ((busy_w[0] || busy_w[1]) && g < 1000) begin
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            g++;
        end
        chk("wrap_drain_timeout", (g >= 1000) ? 1 : 0, 0);
        chk("wrap_all_returned_s1", rsp_cnt[0], acc_cnt[0]);
        chk("wrap_all_returned_s3", rsp_cnt[1], acc_cnt[1]);
        chk("wrap_busy_s1", int'(busy_w[0]), 0);
        chk("wrap_busy_s3", int'(busy_w[1]), 0);

        // ---------------- reset mid-DRIVE ----------------
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_a = 4'(k + 5); cmd_b = 4'(k); cmd_op = 3'(k); cmd_valid = 1'b1;
            step();
        end
        chk("pre_rst_count_s3", int'(count_w[1]), 3);
        chk("pre_rst_busy_s3", int'(busy_w[1]), 1);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("arst_cmd_ready", int'(cmd_ready_w[k]), 1);
            chk("arst_count", int'(count_w[k]), 0);
            chk("arst_busy", int'(busy_w[k]), 0);
            chk("arst_rsp_valid", int'(rsp_valid_w[k]), 0);
            chk("arst_rsp_result", int'(rsp_result_w[k]), 0);
            chk("arst_rsp_op", int'(rsp_op_w[k]), 0);
            chk("arst_alu_a", int'(alu_a_w[k]), 0);
            chk("arst_alu_op", int'(alu_op_w[k]), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("post_rst_no_rsp_s1", int'(rsp_valid_w[0]), 0);
            chk("post_rst_no_rsp_s3", int'(rsp_valid_w[1]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side sequencer that drives the 4-bit combinational ALU.
- Accepts operation commands (A, B, 3-bit opcode) over a valid/ready interface and buffers them in a small FIFO.
- Presents each command to the ALU operand/opcode inputs, waits a programmable settle time, captures the ALU result, and returns it over a valid/ready response interface.
- Sits between the control/test logic that issues ALU work and the ALU datapath.
- Exactly one operation is outstanding at the ALU at any time.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries. Power of two, 2..16.
- SETTLE, 1: clock edges the ALU inputs are held before the result is sampled. Range 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH).
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_op  in  3  ALU opcode (C[2:0]); passed through opaquely.
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_result  in  4  combinational ALU output.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  4  captured ALU result.
- rsp_op  out  3  opcode that produced rsp_result.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  (state != IDLE) or (count != 0).

## Operation
- **FIFO**
  - A push occurs when cmd_valid && cmd_ready at an edge.
  - A pop occurs on the FSM transition into DRIVE.
  - Push and pop in the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - There is no bypass: a command pushed into an empty FIFO is popped no earlier than the following edge.
  - When the FIFO is full, cmd_ready is low even if a pop occurs that edge.
- **FSM states**
  - IDLE
    - count != 0: pop the head into alu_a/alu_b/alu_op, load settle counter with SETTLE-1, go to DRIVE.
    - Otherwise stay in IDLE.
  - DRIVE
    - Counter != 0: decrement and stay in DRIVE.
    - Counter == 0: rsp_result <= alu_result, rsp_op <= alu_op, rsp_valid <= 1, go to WAIT.
  - WAIT
    - rsp_valid && rsp_ready: clear rsp_valid. If count != 0, pop the next command in the same edge and go to DRIVE; otherwise go to IDLE.
    - Otherwise stay in WAIT, holding all rsp_* stable.
- alu_a/alu_b/alu_op change only on a pop. They hold their last values in IDLE and WAIT.
- rsp_result/rsp_op change only on capture.
- No arithmetic is performed here. Widths pass through unchanged.

## Timing
- **Reset values** (asynchronous, immediate on rst_n low):
  - alu_a = 0, alu_b = 0, alu_op = 0
  - rsp_valid = 0, rsp_result = 0, rsp_op = 0
  - count = 0, FIFO pointers = 0
  - state = IDLE, settle counter = 0
  - busy = 0, cmd_ready = 1
- **Latency**
  - Command pushed into an empty FIFO with the FSM in IDLE at edge t: popped at t+1, ALU inputs valid after t+1, result sampled at edge t+1+SETTLE.
  - rsp_valid is therefore high after edge t+1+SETTLE.
- **Throughput**
  - With rsp_ready held high and the FIFO non-empty, one response every SETTLE+1 edges.
- **Handshakes**
  - rsp_valid never drops without rsp_ready.
  - cmd_ready depends only on registered count (no combinational path from rsp_ready).
- **Reset mid-operation**
  - In-flight and queued commands are discarded.
  - No response is emitted for them after reset release.

## Test plan
- **Reset:** assert rst_n=0 mid-DRIVE with 3 queued commands.
  - Immediately: all outputs at reset values, cmd_ready=1, count=0.
  - After release: no rsp_valid.
- **Single op, SETTLE=1:** bench ALU model is alu_result = alu_a ^ alu_b. Push A=4'b1100, B=4'b0001, op=3'b000 at edge 0.
  - alu_a=1100 after edge 1.
  - rsp_valid=1, rsp_result=4'b1101, rsp_op=000 after edge 2.
- **Backpressure:** hold rsp_ready=0 for 10 cycles after the response and push 5 commands (DEPTH=4).
  - rsp_* stable throughout.
  - Fifth push is refused (cmd_ready=0 at count=4).
  - After rsp_ready=1, responses return in push order.
- **Streaming, SETTLE=3:** push 8 commands A=i, B=4'hF, op=i[2:0] with rsp_ready=1.
  - rsp_result = i ^ 4'hF in order.
  - Responses spaced exactly 4 edges apart.
- **Full boundary:** at count=DEPTH, assert cmd_valid in the same edge the FSM pops.
  - No push occurs; count becomes DEPTH-1.
  - cmd_ready rises on the next cycle.
- **Wrap-around:** push/pop 3×DEPTH+1 commands with random rsp_ready.
  - Pointers wrap with no lost, duplicated, or reordered responses.
  - busy falls to 0 only after the final handshake.
